// File: rtl/asap_link_pkg.sv
// Shared definitions for the ASAP tile pin-level access link:
// uio_in/uio_out bit positions and the host initiator FSM states.
package asap_link_pkg;

  localparam int unsigned UIO_STB   = 0;
  localparam int unsigned UIO_WR    = 1;
  localparam int unsigned UIO_PHASE = 2;
  localparam int unsigned UIO_ACK   = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_A_STB = 3'd1,
    ST_A_REL = 3'd2,
    ST_D_STB = 3'd3,
    ST_D_REL = 3'd4,
    ST_RESP  = 3'd5
  } state_e;

endpackage

// File: rtl/asap_sync.sv
// Multi-flop synchronizer for a single asynchronous pin input; resets to 0.
module asap_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;

  // Shift the raw pin through the flop chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
    end else begin
      chain_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        chain_q[i] <= chain_q[i-1];
      end
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/asap_host_link.sv
// Host-side initiator: turns byte read/write requests into the tile's
// four-phase address/data STB/ACK handshake and returns one response each.
module asap_host_link
  import asap_link_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic [7:0] pin_ui_in,
  output logic [7:0] pin_uio_in,
  input  logic [7:0] pin_uo_out,
  input  logic [7:0] pin_uio_out
);

  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [7:0]  ui_q, ui_d;
  logic        stb_q, stb_d;
  logic        wrpin_q, wrpin_d;
  logic        phase_q, phase_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [7:0]  rsp_rdata_q, rsp_rdata_d;

  logic ack_s;
  logic timeout_s;
  logic go_resp_s;
  logic err_s;
  logic unused_s;

  // Only the ACK bit of uio_out is meaningful to the host
  assign unused_s = ^pin_uio_out;

  asap_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (pin_uio_out[UIO_ACK]),
    .q_o   (ack_s)
  );

  assign timeout_s = (cnt_q == TIMEOUT_LIM);

  // Handshake sequencing, timeout supervision and response formation
  always_comb begin
    state_d   = state_q;
    cnt_d     = 16'd0;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    ui_d      = ui_q;
    stb_d     = stb_q;
    wrpin_d   = wrpin_q;
    phase_d   = phase_q;
    go_resp_s = 1'b0;
    err_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          wdata_d = req_wdata;
          rdata_d = 8'h00;
          ui_d    = req_addr;
          wrpin_d = req_write;
          phase_d = 1'b0;
          stb_d   = 1'b1;
          state_d = ST_A_STB;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_A_STB: begin
        if (ack_s) begin
          stb_d   = 1'b0;
          state_d = ST_A_REL;
        end else if (timeout_s) begin
          err_s = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_A_REL: begin
        if (!ack_s) begin
          ui_d    = wr_q ? wdata_q : 8'h00;
          phase_d = 1'b1;
          stb_d   = 1'b1;
          state_d = ST_D_STB;
        end else if (timeout_s) begin
          err_s = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_D_STB: begin
        if (ack_s) begin
          rdata_d = wr_q ? 8'h00 : pin_uo_out;
          stb_d   = 1'b0;
          state_d = ST_D_REL;
        end else if (timeout_s) begin
          err_s = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_D_REL: begin
        if (!ack_s) begin
          go_resp_s = 1'b1;
        end else if (timeout_s) begin
          err_s = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Entering RESP releases every pin and launches the one-cycle response
    if (go_resp_s || err_s) begin
      state_d     = ST_RESP;
      ui_d        = 8'h00;
      stb_d       = 1'b0;
      wrpin_d     = 1'b0;
      phase_d     = 1'b0;
      rsp_valid_d = 1'b1;
      rsp_err_d   = err_s;
      rsp_rdata_d = err_s ? 8'h00 : rdata_q;
    end else begin
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = 8'h00;
    end
    req_ready_d = (state_d == ST_IDLE);
  end

  // State, latched request and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 16'd0;
      wr_q        <= 1'b0;
      wdata_q     <= 8'h00;
      rdata_q     <= 8'h00;
      ui_q        <= 8'h00;
      stb_q       <= 1'b0;
      wrpin_q     <= 1'b0;
      phase_q     <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      ui_q        <= ui_d;
      stb_q       <= stb_d;
      wrpin_q     <= wrpin_d;
      phase_q     <= phase_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Assemble the uio_in pin byte from its registered control bits
  always_comb begin
    pin_uio_in            = 8'h00;
    pin_uio_in[UIO_STB]   = stb_q;
    pin_uio_in[UIO_WR]    = wrpin_q;
    pin_uio_in[UIO_PHASE] = phase_q;
  end

  assign pin_ui_in = ui_q;
  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_asap_host_link.sv
// Directed bench for asap_host_link: table of single transactions against a
// delay-configurable tile model, plus timeout, back-to-back and reset cases.
module tb_asap_host_link;

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] trd;
    int         dly;
    logic [7:0] exp_rdata;
    int         exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic       req_valid, req_ready, req_write, rsp_valid, rsp_err;
  logic [7:0] req_addr, req_wdata, rsp_rdata, pin_ui_in, pin_uio_in, pin_uo_out, pin_uio_out;

  logic       req_valid2, req_ready2, req_write2, rsp_valid2, rsp_err2;
  logic [7:0] req_addr2, req_wdata2, rsp_rdata2, pin_ui_in2, pin_uio_in2;
  logic [7:0] pin_uo_out2, pin_uio_out2;

  int checks = 0;
  int passes = 0;

  int         tile_dly = 0;
  logic [7:0] tile_rdata = 8'h00;
  logic       ack_r = 1'b0;
  int         dly_cnt = 0;
  logic       tile_ack;
  logic       prev_stb = 1'b0;
  int         stb_rises = 0;
  logic [7:0] a_ui = 8'h00, a_uio = 8'h00, d_ui = 8'h00, d_uio = 8'h00;

  int         got_lat, ready_seen;
  logic       got_rsp, got_err;
  logic [7:0] got_rdata;

  always #5 clk = ~clk;

  asap_host_link dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .pin_ui_in(pin_ui_in), .pin_uio_in(pin_uio_in),
    .pin_uo_out(pin_uo_out), .pin_uio_out(pin_uio_out)
  );

  asap_host_link #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(8)) dut_to (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid2), .req_ready(req_ready2), .req_write(req_write2),
    .req_addr(req_addr2), .req_wdata(req_wdata2),
    .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2),
    .pin_ui_in(pin_ui_in2), .pin_uio_in(pin_uio_in2),
    .pin_uo_out(pin_uo_out2), .pin_uio_out(pin_uio_out2)
  );

  // Tile model: ACK follows STB after tile_dly cycles (combinational when 0)
  always @(posedge clk) begin
    if (pin_uio_in[0] != ack_r) begin
      if (dly_cnt >= tile_dly - 1) begin
        ack_r   <= pin_uio_in[0];
        dly_cnt <= 0;
      end else begin
        dly_cnt <= dly_cnt + 1;
      end
    end else begin
      dly_cnt <= 0;
    end
  end

  assign tile_ack    = (tile_dly == 0) ? pin_uio_in[0] : ack_r;
  assign pin_uio_out = {4'hA, tile_ack, 3'b101};
  assign pin_uo_out  = (tile_ack && pin_uio_in[2] && !pin_uio_in[1]) ? tile_rdata : 8'hEE;
  assign pin_uo_out2  = 8'h00;
  assign pin_uio_out2 = 8'h00;

  // Tile-side log of what the pins carried at each STB rise
  always @(posedge clk) begin
    prev_stb <= pin_uio_in[0];
    if (pin_uio_in[0] && !prev_stb) begin
      stb_rises <= stb_rises + 1;
      if (pin_uio_in[2]) begin
        d_ui  <= pin_ui_in;
        d_uio <= pin_uio_in;
      end else begin
        a_ui  <= pin_ui_in;
        a_uio <= pin_uio_in;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic start_req(input logic wr, input logic [7:0] addr, input logic [7:0] wdata);
    int w;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    w = 0;
    while (!req_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) chk("accept_wait", 0, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic run_txn(input vec_t v);
    tile_dly   = v.dly;
    tile_rdata = v.trd;
    start_req(v.wr, v.addr, v.wdata);
    got_lat = 1; ready_seen = 0; got_rsp = 1'b0; got_err = 1'b0; got_rdata = 8'h00;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      got_lat++;
      if (rsp_valid) begin
        got_rsp = 1'b1; got_err = rsp_err; got_rdata = rsp_rdata;
        break;
      end
      if (req_ready) ready_seen++;
    end
    if (!got_rsp) chk("rsp_wait", 0, 1);
    @(negedge clk);
  endtask

  vec_t vecs[5];
  vec_t v;

  initial begin
    int acc, resp, ovl, r0, k, kd, kr, rv;
    logic found, e;
    logic [7:0] r;

    req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    req_valid2 = 1'b0; req_write2 = 1'b0; req_addr2 = 8'h00; req_wdata2 = 8'h00;

    vecs[0] = '{wr:1'b1, addr:8'h12, wdata:8'hA5, trd:8'h00, dly:0,  exp_rdata:8'h00, exp_lat:14};
    vecs[1] = '{wr:1'b0, addr:8'h40, wdata:8'h00, trd:8'h3C, dly:0,  exp_rdata:8'h3C, exp_lat:14};
    vecs[2] = '{wr:1'b1, addr:8'h7F, wdata:8'h5A, trd:8'h00, dly:20, exp_rdata:8'h00, exp_lat:94};
    vecs[3] = '{wr:1'b0, addr:8'h81, wdata:8'h11, trd:8'hC3, dly:20, exp_rdata:8'hC3, exp_lat:94};
    vecs[4] = '{wr:1'b0, addr:8'h01, wdata:8'h00, trd:8'hFF, dly:1,  exp_rdata:8'hFF, exp_lat:18};

    #2 rst_n = 1'b0;
    #1;
    chk("rst_req_ready", int'(req_ready), 1);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_rdata", int'(rsp_rdata), 0);
    chk("rst_rsp_err",   int'(rsp_err), 0);
    chk("rst_pin_ui",    int'(pin_ui_in), 0);
    chk("rst_pin_uio",   int'(pin_uio_in), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      v = vecs[i];
      run_txn(v);
      chk("rdata",      int'(got_rdata), int'(v.exp_rdata));
      chk("err",        int'(got_err), 0);
      chk("latency",    got_lat, v.exp_lat);
      chk("ready_busy", ready_seen, 0);
      chk("a_ui",       int'(a_ui), int'(v.addr));
      chk("a_uio",      int'(a_uio), v.wr ? 3 : 1);
      chk("d_ui",       int'(d_ui), v.wr ? int'(v.wdata) : 0);
      chk("d_uio",      int'(d_uio), v.wr ? 7 : 5);
    end

    // Timeout on the short-timeout instance whose tile never acknowledges
    @(negedge clk);
    req_valid2 = 1'b1; req_write2 = 1'b0; req_addr2 = 8'h99;
    @(posedge clk);
    #1 req_valid2 = 1'b0;
    @(negedge clk);
    chk("to_stb_rise", int'(pin_uio_in2[0]), 1);
    k = 0; kd = -1; kr = -1; e = 1'b0; r = 8'hAA;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      k++;
      if (!pin_uio_in2[0] && kd < 0) kd = k;
      if (rsp_valid2) begin
        kr = k; e = rsp_err2; r = rsp_rdata2;
        break;
      end
    end
    chk("to_stb_drop", kd, 9);
    chk("to_rsp_cycle", kr, 9);
    chk("to_err", int'(e), 1);
    chk("to_rdata", int'(r), 0);

    // Back-to-back writes with req_valid held high
    tile_dly = 0; r0 = stb_rises; acc = 0; resp = 0; ovl = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h55; req_wdata = 8'h0F;
    for (int i = 0; i < 80; i++) begin
      if (rsp_valid) resp++;
      if (pin_uio_in[0] && req_ready) ovl++;
      if (req_valid && req_ready) begin
        acc++;
        if (acc == 3) begin
          @(posedge clk);
          #1 req_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    chk("b2b_accepts", acc, 3);
    chk("b2b_responses", resp, 3);
    chk("b2b_stb_rises", stb_rises - r0, 6);
    chk("b2b_overlap", ovl, 0);

    // Reset asserted while the data-phase strobe is up
    tile_dly = 0; tile_rdata = 8'h77;
    start_req(1'b0, 8'h22, 8'h00);
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (pin_uio_in == 8'h05) begin
        found = 1'b1;
        break;
      end
    end
    chk("reach_dstb", int'(found), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_uio", int'(pin_uio_in), 0);
    chk("mid_rst_ui", int'(pin_ui_in), 0);
    chk("mid_rst_ready", int'(req_ready), 1);
    rv = 0;
    repeat (3) begin
      @(negedge clk);
      rv += int'(rsp_valid);
    end
    rst_n = 1'b1;
    chk("mid_rst_no_rsp", rv, 0);
    v = '{wr:1'b0, addr:8'h33, wdata:8'h00, trd:8'h5A, dly:0, exp_rdata:8'h5A, exp_lat:14};
    run_txn(v);
    chk("post_rst_rdata", int'(got_rdata), 8'h5A);
    chk("post_rst_err", int'(got_err), 0);
    chk("post_rst_lat", got_lat, 14);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
